ravenna_spi_master: RTL and testbench

RAVENNA_SPI_MASTER -- requirements
Module: ravenna_spi_master

---
 rtl/ravenna_spi_pkg.sv | 24 ++
 rtl/ravenna_spi_master_if.sv | 33 +++
 rtl/ravenna_spi_clkdiv.sv | 37 +++
 rtl/ravenna_spi_master.sv | 160 ++++++++++++++++
 tb/tb_ravenna_spi_master.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ravenna_spi_pkg.sv
// Shared types and constants for the Ravenna SPI master: FSM state encoding,
// SPI mode selection and per-byte SCK tick bookkeeping.
package ravenna_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

    // Mode 0: SCK idles low, data sampled on the rising (leading) edge.
    localparam logic [1:0] SPI_MODE = 2'b00;
    localparam logic       SPI_CPOL = SPI_MODE[1];

    // SHIFT-state tick indices: even ticks are falling edges, tick 15 ends the byte.
    localparam logic [3:0] SCK_LAST_FALL = 4'd14;
    localparam logic [3:0] SCK_LAST_TICK = 4'd15;

    function automatic logic [7:0] shift_in_bit(input logic [7:0] cur, input logic bit_in);
        return {cur[6:0], bit_in};
    endfunction

endpackage

// File: rtl/ravenna_spi_master_if.sv
// Host-side and pin-side signal bundle of the SPI master. The slave modport is
// the block itself; the master modport is whoever drives it.
interface ravenna_spi_master_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 enable;
    logic [DIV_WIDTH-1:0] prescale;
    logic                 hold;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 busy;
    logic                 irq_en;
    logic                 irq_clr;
    logic                 irq;
    logic                 spi_csb;
    logic                 spi_sck;
    logic                 spi_sdo;
    logic                 spi_sdi;

    modport master (
        output enable, prescale, hold, tx_data, tx_valid, irq_en, irq_clr, spi_sdi,
        input  tx_ready, rx_data, rx_valid, busy, irq, spi_csb, spi_sck, spi_sdo
    );

    modport slave (
        input  enable, prescale, hold, tx_data, tx_valid, irq_en, irq_clr, spi_sdi,
        output tx_ready, rx_data, rx_valid, busy, irq, spi_csb, spi_sck, spi_sdo
    );

endinterface

// File: rtl/ravenna_spi_clkdiv.sv
// SCK prescaler: latches the half-period on load, then emits a one-cycle tick
// every prescale+1 cycles while running.
module ravenna_spi_clkdiv #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_load,
    input  logic                 i_run,
    input  logic [DIV_WIDTH-1:0] i_prescale,
    output logic                 o_tick
);
    logic [DIV_WIDTH-1:0] r_period;
    logic [DIV_WIDTH-1:0] r_cnt;

    assign o_tick = i_run & (r_cnt == {DIV_WIDTH{1'b0}});

    // Down-counter that reloads the latched period on every tick.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_period <= {DIV_WIDTH{1'b0}};
            r_cnt    <= {DIV_WIDTH{1'b0}};
        end else if (i_load) begin
            r_period <= i_prescale;
            r_cnt    <= i_prescale;
        end else if (i_run) begin
            if (r_cnt == {DIV_WIDTH{1'b0}}) begin
                r_cnt <= r_period;
            end else begin
                r_cnt <= r_cnt - DIV_WIDTH'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/ravenna_spi_master.sv
// Ravenna SPI mode-0 master: one byte per handshake, optional chip-select hold
// for streaming, sticky completion interrupt.
module ravenna_spi_master
    import ravenna_spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    ravenna_spi_master_if.slave bus
);
    spi_state_e r_state;
    spi_state_e w_state_nxt;

    logic       w_tx_ready;
    logic       w_accept;
    logic       w_run;
    logic       w_tick;
    logic [3:0] r_tog;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_csb;
    logic       r_sck;
    logic       r_irq;

    assign w_tx_ready = (r_state == ST_IDLE) & bus.enable;
    assign w_accept   = w_tx_ready & bus.tx_valid;
    assign w_run      = bus.enable & ((r_state == ST_SETUP) | (r_state == ST_SHIFT));

    ravenna_spi_clkdiv #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clkdiv (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_accept),
        .i_run      (w_run),
        .i_prescale (bus.prescale),
        .o_tick     (w_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping enable wins over every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = w_accept ? ST_SETUP : ST_IDLE;
                ST_SETUP: w_state_nxt = w_tick ? ST_SHIFT : ST_SETUP;
                ST_SHIFT: w_state_nxt = (w_tick && (r_tog == SCK_LAST_TICK)) ? ST_DONE : ST_SHIFT;
                ST_DONE:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Shift datapath and SPI pins; SETUP's tick is the first rising SCK edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_csb      <= 1'b1;
            r_sck      <= SPI_CPOL;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tog      <= 4'd0;
        end else begin
            r_rx_valid <= 1'b0;
            if (!bus.enable) begin
                r_csb <= 1'b1;
                r_sck <= SPI_CPOL;
                r_tx  <= 8'h00;
                r_tog <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_csb <= 1'b0;
                            r_sck <= SPI_CPOL;
                            r_tx  <= bus.tx_data;
                            r_tog <= 4'd0;
                        end else if (!bus.hold) begin
                            r_csb <= 1'b1;
                            r_tx  <= 8'h00;
                        end
                    end
                    ST_SETUP: begin
                        if (w_tick) begin
                            r_sck <= ~SPI_CPOL;
                            r_rx  <= shift_in_bit(r_rx, bus.spi_sdi);
                        end
                    end
                    ST_SHIFT: begin
                        if (w_tick) begin
                            r_tog <= r_tog + 4'd1;
                            if (r_tog == SCK_LAST_TICK) begin
                                r_rx_data  <= r_rx;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_sck <= ~r_sck;
                                if (r_sck != SPI_CPOL) begin
                                    if (r_tog != SCK_LAST_FALL) begin
                                        r_tx <= {r_tx[6:0], 1'b0};
                                    end
                                end else begin
                                    r_rx <= shift_in_bit(r_rx, bus.spi_sdi);
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!bus.hold) begin
                            r_csb <= 1'b1;
                            r_tx  <= 8'h00;
                        end
                    end
                    default: begin
                        r_csb <= 1'b1;
                        r_sck <= SPI_CPOL;
                        r_tx  <= 8'h00;
                    end
                endcase
            end
        end
    end

    // Sticky interrupt; a completion in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else if (r_rx_valid && bus.irq_en) begin
            r_irq <= 1'b1;
        end else if (bus.irq_clr) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq;
        end
    end

    assign bus.tx_ready = w_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.irq      = r_irq;
    assign bus.spi_csb  = r_csb;
    assign bus.spi_sck  = r_sck;
    assign bus.spi_sdo  = r_tx[7];

endmodule

// File: tb/tb_ravenna_spi_master.sv
// Scoreboard bench for ravenna_spi_master: the driver queues the expected byte
// and completion cycle, a monitor checks every rx_valid and SCK edge against it.
module tb_ravenna_spi_master;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ravenna_spi_master_if #(.DIV_WIDTH(8)) bus();

    ravenna_spi_master #(.DIV_WIDTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Behavioural slave: echoes SDO, optionally inverted.
    bit slave_inv = 1'b0;
    assign bus.spi_sdi = bus.spi_sdo ^ slave_inv;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         t;
        int         p;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int   rise_idx  = 0;
    int   last_rise = 0;
    int   rx_count  = 0;
    int   csb_high  = 0;
    bit   watch_csb = 1'b0;
    logic prev_sck  = 1'b0;
    logic prev_rxv  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: SCK timing, rx_valid against scoreboard, SDO quiet while deselected.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.spi_csb) check("sdo_when_csb_high", bus.spi_sdo, 1'b0);
            if (watch_csb && bus.spi_csb) csb_high++;
            if (bus.spi_sck && !prev_sck) begin
                if (exp_q.size() == 0) begin
                    fail("sck_rise_without_transfer");
                end else if (rise_idx == 0) begin
                    check("first_sck_rise_cycle", cyc, exp_q[0].t + 1 + exp_q[0].p);
                end else begin
                    check("sck_period", cyc - last_rise, 2 * exp_q[0].p);
                end
                last_rise = cyc;
                rise_idx++;
            end
            if (bus.rx_valid) begin
                check("rx_valid_one_cycle", prev_rxv, 1'b0);
                rx_count++;
                if (exp_q.size() == 0) begin
                    fail("rx_valid_unexpected");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_data", bus.rx_data, mon_e.data);
                    check("rx_latency", cyc, mon_e.t + 1 + 17 * mon_e.p);
                    check("sck_rises_per_byte", rise_idx, 8);
                end
                rise_idx = 0;
            end
        end
        prev_sck = bus.spi_sck;
        prev_rxv = bus.rx_valid;
    end

    task automatic send(input logic [7:0] d, input int pre, input bit h, output int t);
        @(negedge clk);
        bus.tx_data  = d;
        bus.prescale = pre[7:0];
        bus.hold     = h;
        bus.tx_valid = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            if (bus.tx_ready) break;
            @(negedge clk);
        end
        if (!bus.tx_ready) begin
            fail("tx_ready_timeout");
            bus.tx_valid = 1'b0;
            t = -1;
        end else begin
            t = cyc;
            exp_q.push_back('{d ^ {8{slave_inv}}, cyc, pre + 1});
            @(posedge clk);
            #1 bus.tx_valid = 1'b0;
        end
    endtask

    task automatic wait_rx();
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (bus.rx_valid) return;
        end
        fail("rx_valid_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csb"},      bus.spi_csb,  1'b1);
        check({tag, "_sck"},      bus.spi_sck,  1'b0);
        check({tag, "_sdo"},      bus.spi_sdo,  1'b0);
        check({tag, "_rx_data"},  bus.rx_data,  8'h00);
        check({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
        check({tag, "_irq"},      bus.irq,      1'b0);
        check({tag, "_busy"},     bus.busy,     1'b0);
    endtask

    initial begin
        int t;
        int rx0;
        int n;
        logic pm;

        bus.enable   = 1'b1;
        bus.prescale = 8'd0;
        bus.hold     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.irq_en   = 1'b0;
        bus.irq_clr  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);
        check("tx_ready_after_reset", bus.tx_ready, 1'b1);

        // Loopback, fastest SCK; chip select rises the cycle after DONE.
        slave_inv = 1'b0;
        send(8'hA5, 0, 1'b0, t);
        wait_rx();
        @(negedge clk);
        check("csb_high_after_byte", bus.spi_csb, 1'b1);
        check("csb_high_cycle", cyc, t + 19);

        // Slave returns the complement, SCK period 8 clocks.
        slave_inv = 1'b1;
        send(8'h3C, 3, 1'b0, t);
        wait_rx();
        check("rx_c3_cycle", cyc, t + 69);

        // Streaming three bytes with chip select held low throughout.
        slave_inv = 1'b0;
        rx0 = rx_count;
        csb_high = 0;
        send(8'h01, 1, 1'b1, t);
        watch_csb = 1'b1;
        send(8'h02, 1, 1'b1, t);
        send(8'h03, 1, 1'b1, t);
        wait_rx();
        watch_csb = 1'b0;
        bus.hold = 1'b0;
        check("stream_csb_high_cycles", csb_high, 0);
        check("stream_rx_pulses", rx_count - rx0, 3);
        @(negedge clk);
        check("stream_csb_release", bus.spi_csb, 1'b1);

        // Abort after the third SCK rise, then a clean transfer.
        send(8'hFF, 1, 1'b0, t);
        n = 0;
        pm = bus.spi_sck;
        for (int k = 0; k < 500 && n < 3; k++) begin
            @(negedge clk);
            if (bus.spi_sck && !pm) n++;
            pm = bus.spi_sck;
        end
        check("abort_rises_seen", n, 3);
        bus.enable = 1'b0;
        @(negedge clk);
        check("abort_csb", bus.spi_csb, 1'b1);
        check("abort_sck", bus.spi_sck, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_tx_ready", bus.tx_ready, 1'b0);
        exp_q.delete();
        rise_idx = 0;
        rx0 = rx_count;
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_rx_valid", rx_count - rx0, 0);
        send(8'h55, 1, 1'b0, t);
        wait_rx();

        // Set beats clear in the rx_valid cycle; clear takes effect one cycle on.
        bus.irq_en = 1'b1;
        send(8'h5A, 0, 1'b0, t);
        wait_rx();
        bus.irq_clr = 1'b1;
        @(negedge clk);
        check("irq_set_wins", bus.irq, 1'b1);
        @(negedge clk);
        check("irq_cleared", bus.irq, 1'b0);
        bus.irq_clr = 1'b0;

        // Leave irq set, then reset mid-byte between clock edges.
        send(8'hC7, 2, 1'b0, t);
        repeat (12) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1'b1);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        rise_idx = 0;
        bus.irq_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("tx_ready_after_midbyte_reset", bus.tx_ready, 1'b1);

        // Randomized traffic checked by the scoreboard.
        for (int i = 0; i < 30; i++) begin
            slave_inv = bit'($urandom_range(0, 1));
            send(8'($urandom), int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), t);
            wait_rx();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.hold = 1'b0;
        repeat (4) @(negedge clk);
        check("irq_stays_clear_when_disabled", bus.irq, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_csb", bus.spi_csb, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
